// File: rtl/keypad_event_scanner.sv
// rtl/keypad_event_scanner.sv - matrix keypad scanner with debounce, ghost rejection and event FIFO
module keypad_event_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 16,
  parameter int DB_CYCLES      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPORT_RELEASE = 1,
  localparam int CW            = $clog2(ROWS*COLS)
) (
  input  logic            int_osc,
  input  logic            nrst,
  input  logic [ROWS-1:0] row_d,
  output logic [COLS-1:0] column_signals,
  output logic [CW-1:0]   key_code,
  output logic            key_release,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            overflow
);

  localparam int ROWW = $clog2(ROWS);
  localparam int COLW = $clog2(COLS);
  localparam int DWW  = $clog2(SCAN_DIV);
  localparam int DBW  = $clog2(DB_CYCLES + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE_DB} state_t;

  state_t          state;
  logic [ROWS-1:0] row_m, row_s;
  logic [DWW-1:0]  dwell;
  logic [COLW-1:0] col;
  logic [ROWS-1:0] pat;
  logic [DBW-1:0]  db_cnt;
  logic            ghost;
  logic [CW-1:0]   held_code;

  logic            sample, row_zero, same_pat, single;
  logic [ROWS-1:0] nxt_pat;
  logic [DBW-1:0]  nxt_cnt, rel_cnt;
  logic            cap_done, rel_done;
  logic [ROWW-1:0] row_idx;
  logic [CW-1:0]   press_code;
  logic [COLW-1:0] col_adv;
  logic            push, push_rel;
  logic [CW-1:0]   push_code;

  logic [CW:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            full, pop, do_push;

  // Two-flop synchroniser for the asynchronous row pins
  always_ff @(posedge int_osc or negedge nrst) begin
    if (!nrst) begin
      row_m <= '0;
      row_s <= '0;
    end else begin
      row_m <= row_d;
      row_s <= row_m;
    end
  end

  // Free-running dwell counter; its last count is the sample point
  always_ff @(posedge int_osc or negedge nrst) begin
    if (!nrst) dwell <= '0;
    else if (dwell == DWW'(SCAN_DIV - 1)) dwell <= '0;
    else dwell <= dwell + 1'b1;
  end

  // Sample-point decisions: debounce progress, acceptance and the event to queue
  always_comb begin
    sample     = (dwell == DWW'(SCAN_DIV - 1));
    row_zero   = (row_s == '0);
    same_pat   = (state == DEBOUNCE) && (row_s == pat);
    nxt_pat    = row_s;
    nxt_cnt    = same_pat ? db_cnt + 1'b1 : DBW'(1);
    rel_cnt    = (state == RELEASE_DB) ? db_cnt + 1'b1 : DBW'(1);
    single     = $onehot(nxt_pat);
    row_idx    = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (nxt_pat[i]) row_idx = ROWW'(i);
    end
    press_code = CW'(int'(row_idx) * COLS + int'(col));
    col_adv    = (col == COLW'(COLS - 1)) ? '0 : col + 1'b1;
    cap_done   = sample && !row_zero && (state == SCAN || state == DEBOUNCE)
                 && (nxt_cnt >= DBW'(DB_CYCLES));
    rel_done   = sample && row_zero && (state == HELD || state == RELEASE_DB)
                 && (rel_cnt >= DBW'(DB_CYCLES));
    push       = (cap_done && single) || (rel_done && (REPORT_RELEASE != 0) && !ghost);
    push_rel   = rel_done;
    push_code  = rel_done ? held_code : press_code;
  end

  // Scan / debounce / hold / release FSM with the registered column drive
  always_ff @(posedge int_osc or negedge nrst) begin
    if (!nrst) begin
      state          <= SCAN;
      col            <= '0;
      column_signals <= COLS'(1);
      pat            <= '0;
      db_cnt         <= '0;
      ghost          <= 1'b0;
      held_code      <= '0;
    end else if (sample) begin
      case (state)
        SCAN, DEBOUNCE: begin
          if (row_zero) begin
            state <= SCAN;
            if (state == SCAN) begin
              col            <= col_adv;
              column_signals <= COLS'(1) << col_adv;
            end
          end else begin
            pat    <= nxt_pat;
            db_cnt <= nxt_cnt;
            if (cap_done) begin
              state     <= HELD;
              ghost     <= !single;
              held_code <= press_code;
            end else begin
              state <= DEBOUNCE;
            end
          end
        end
        HELD, RELEASE_DB: begin
          if (!row_zero) begin
            state <= HELD;
          end else if (rel_done) begin
            state          <= SCAN;
            col            <= col_adv;
            column_signals <= COLS'(1) << col_adv;
          end else begin
            state  <= RELEASE_DB;
            db_cnt <= rel_cnt;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign full    = (count == (PW+1)'(FIFO_DEPTH));
  assign pop     = key_valid && key_ready;
  assign do_push = push && (!full || pop);

  // Event FIFO; a push into a full FIFO without a pop is dropped and flagged
  always_ff @(posedge int_osc or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {push_rel, push_code};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign key_valid                 = (count != '0);
  assign {key_release, key_code}   = mem[rd_ptr];

endmodule
